// File: rtl/ysyx_23060061_regfile_sb_if.sv
// Bus between the pipeline and the scoreboarded register file: write-back, issue and
// packed read ports.
interface ysyx_23060061_regfile_sb_if #(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NR_READ    = 2
) ();

  logic                          wen;
  logic [ADDR_WIDTH-1:0]         waddr;
  logic [DATA_WIDTH-1:0]         wdata;
  logic                          issue_valid;
  logic [ADDR_WIDTH-1:0]         issue_rd;
  logic [NR_READ*ADDR_WIDTH-1:0] raddr;
  logic [NR_READ*DATA_WIDTH-1:0] rdata;
  logic [NR_READ-1:0]            rbusy;
  logic                          any_busy;

  modport master (
    output wen, waddr, wdata, issue_valid, issue_rd, raddr,
    input  rdata, rbusy, any_busy
  );

  modport slave (
    input  wen, waddr, wdata, issue_valid, issue_rd, raddr,
    output rdata, rbusy, any_busy
  );

endinterface

// File: rtl/ysyx_23060061_regfile_sb.sv
// Register file with N bypassed combinational read ports, one write port, optional
// hardwired zero register and a per-register busy scoreboard.
module ysyx_23060061_regfile_sb #(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NR_READ    = 2,
  parameter bit          ZERO_REG   = 1'b1
) (
  input logic                       clk,
  input logic                       rst,
  ysyx_23060061_regfile_sb_if.slave bus
);

  localparam int unsigned Depth = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] rf_q [Depth];
  logic [Depth-1:0]      busy_q;
  logic [Depth-1:0]      busy_d;
  logic                  wr_en;

  assign wr_en = bus.wen && !(ZERO_REG && (bus.waddr == '0));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned k = 0; k < Depth; k++) begin
        rf_q[k] <= '0;
      end
    end else if (wr_en) begin
      rf_q[bus.waddr] <= bus.wdata;
    end
  end

  // Issue beats write-back on the same index: a newer producer replaces the retiring one.
  always_comb begin
    busy_d = busy_q;
    for (int unsigned k = 0; k < Depth; k++) begin
      if (bus.issue_valid && (bus.issue_rd == ADDR_WIDTH'(k))) begin
        busy_d[k] = 1'b1;
      end else if (bus.wen && (bus.waddr == ADDR_WIDTH'(k))) begin
        busy_d[k] = 1'b0;
      end
    end
    if (ZERO_REG) begin
      busy_d[0] = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign bus.any_busy = |busy_q;

  for (genvar i = 0; i < NR_READ; i++) begin : g_rd
    logic [ADDR_WIDTH-1:0] ra;
    logic                  is_zero;
    logic                  hit;

    assign ra      = bus.raddr[i*ADDR_WIDTH +: ADDR_WIDTH];
    assign is_zero = ZERO_REG && (ra == '0);
    assign hit     = bus.wen && (bus.waddr == ra);

    assign bus.rdata[i*DATA_WIDTH +: DATA_WIDTH] = is_zero ? '0        :
                                                   hit     ? bus.wdata : rf_q[ra];
    // A write-back landing this cycle makes the operand ready through the bypass.
    assign bus.rbusy[i] = !is_zero && busy_q[ra] && !hit;
  end

endmodule

// File: tb/tb_ysyx_23060061_regfile_sb.sv
// Directed vector table on the default configuration plus random traffic against a
// reference model on a 3-port, 16-entry, 64-bit instance.
module tb_ysyx_23060061_regfile_sb;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ysyx_23060061_regfile_sb_if #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .NR_READ(2)) bus0 ();
  ysyx_23060061_regfile_sb_if #(.ADDR_WIDTH(4), .DATA_WIDTH(64), .NR_READ(3)) bus1 ();

  ysyx_23060061_regfile_sb #(
    .ADDR_WIDTH(5), .DATA_WIDTH(32), .NR_READ(2), .ZERO_REG(1'b1)
  ) u_dut0 (
    .clk(clk),
    .rst(rst),
    .bus(bus0)
  );

  ysyx_23060061_regfile_sb #(
    .ADDR_WIDTH(4), .DATA_WIDTH(64), .NR_READ(3), .ZERO_REG(1'b1)
  ) u_dut1 (
    .clk(clk),
    .rst(rst),
    .bus(bus1)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        wen;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        iv;
    logic [4:0]  ird;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [31:0] e0;
    logic [31:0] e1;
    logic [1:0]  ebusy;
    logic        eany;
  } vec_t;

  vec_t vecs [21];

  logic [63:0] m_rf [16];
  logic [15:0] m_busy;

  initial begin
    //          wen   waddr  wdata          iv    ird    ra0    ra1    e0             e1             ebusy  eany
    vecs[0]  = '{1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  5'd0,  5'd5,  32'h0,         32'h0,         2'b00, 1'b0};
    vecs[1]  = '{1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  5'd31, 5'd0,  32'h0,         32'h0,         2'b00, 1'b0};
    vecs[2]  = '{1'b1, 5'd3,  32'h12345678,  1'b0, 5'd0,  5'd3,  5'd3,  32'h12345678,  32'h12345678,  2'b00, 1'b0};
    vecs[3]  = '{1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  5'd3,  5'd3,  32'h12345678,  32'h12345678,  2'b00, 1'b0};
    vecs[4]  = '{1'b1, 5'd0,  32'hFFFFFFFF,  1'b1, 5'd0,  5'd0,  5'd0,  32'h0,         32'h0,         2'b00, 1'b0};
    vecs[5]  = '{1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  5'd0,  5'd3,  32'h0,         32'h12345678,  2'b00, 1'b0};
    vecs[6]  = '{1'b0, 5'd0,  32'h0,         1'b1, 5'd10, 5'd10, 5'd3,  32'h0,         32'h12345678,  2'b00, 1'b0};
    vecs[7]  = '{1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  5'd10, 5'd10, 32'h0,         32'h0,         2'b11, 1'b1};
    vecs[8]  = '{1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  5'd10, 5'd0,  32'h0,         32'h0,         2'b01, 1'b1};
    vecs[9]  = '{1'b1, 5'd10, 32'h55,        1'b0, 5'd0,  5'd10, 5'd10, 32'h55,        32'h55,        2'b00, 1'b1};
    vecs[10] = '{1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  5'd10, 5'd3,  32'h55,        32'h12345678,  2'b00, 1'b0};
    vecs[11] = '{1'b0, 5'd0,  32'h0,         1'b1, 5'd12, 5'd12, 5'd12, 32'h0,         32'h0,         2'b00, 1'b0};
    vecs[12] = '{1'b1, 5'd12, 32'hAA,        1'b1, 5'd12, 5'd12, 5'd12, 32'hAA,        32'hAA,        2'b00, 1'b1};
    vecs[13] = '{1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  5'd12, 5'd12, 32'hAA,        32'hAA,        2'b11, 1'b1};
    vecs[14] = '{1'b1, 5'd12, 32'hBB,        1'b0, 5'd0,  5'd12, 5'd5,  32'hBB,        32'h0,         2'b00, 1'b1};
    vecs[15] = '{1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  5'd12, 5'd12, 32'hBB,        32'hBB,        2'b00, 1'b0};
    vecs[16] = '{1'b1, 5'd5,  32'h5,         1'b0, 5'd0,  5'd5,  5'd12, 32'h5,         32'hBB,        2'b00, 1'b0};
    vecs[17] = '{1'b0, 5'd0,  32'h0,         1'b1, 5'd7,  5'd7,  5'd7,  32'h0,         32'h0,         2'b00, 1'b0};
    vecs[18] = '{1'b0, 5'd0,  32'h0,         1'b1, 5'd7,  5'd7,  5'd7,  32'h0,         32'h0,         2'b11, 1'b1};
    vecs[19] = '{1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  5'd7,  5'd7,  32'h0,         32'h0,         2'b11, 1'b1};
    vecs[20] = '{1'b1, 5'd7,  32'hDEADBEEF,  1'b0, 5'd0,  5'd7,  5'd7,  32'hDEADBEEF,  32'hDEADBEEF,  2'b00, 1'b1};

    bus0.wen = 1'b0; bus0.waddr = '0; bus0.wdata = '0;
    bus0.issue_valid = 1'b0; bus0.issue_rd = '0; bus0.raddr = '0;
    bus1.wen = 1'b0; bus1.waddr = '0; bus1.wdata = '0;
    bus1.issue_valid = 1'b0; bus1.issue_rd = '0; bus1.raddr = '0;

    rst = 1'b1;
    #12;
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 21; i++) begin
      if (i != 0) @(negedge clk);
      bus0.wen         = vecs[i].wen;
      bus0.waddr       = vecs[i].waddr;
      bus0.wdata       = vecs[i].wdata;
      bus0.issue_valid = vecs[i].iv;
      bus0.issue_rd    = vecs[i].ird;
      bus0.raddr       = {vecs[i].ra1, vecs[i].ra0};
      #1;
      check($sformatf("v%0d rdata0", i), 192'(bus0.rdata[31:0]), 192'(vecs[i].e0));
      check($sformatf("v%0d rdata1", i), 192'(bus0.rdata[63:32]), 192'(vecs[i].e1));
      check($sformatf("v%0d rbusy", i), 192'(bus0.rbusy), 192'(vecs[i].ebusy));
      check($sformatf("v%0d any_busy", i), 192'(bus0.any_busy), 192'(vecs[i].eany));
    end

    // Mid-run asynchronous reset: r7 holds DEADBEEF, r4 is made busy first.
    @(negedge clk);
    bus0.wen = 1'b0; bus0.issue_valid = 1'b1; bus0.issue_rd = 5'd4;
    bus0.raddr = {5'd3, 5'd7};
    #1;
    check("pre-reset r7", 192'(bus0.rdata[31:0]), 192'(32'hDEADBEEF));
    @(negedge clk);
    bus0.issue_valid = 1'b0;
    #1;
    check("pre-reset any_busy", 192'(bus0.any_busy), 192'(1'b1));
    rst = 1'b1;
    #1;
    check("reset r7 immediate", 192'(bus0.rdata[31:0]), 192'(32'h0));
    check("reset r3 immediate", 192'(bus0.rdata[63:32]), 192'(32'h0));
    check("reset any_busy immediate", 192'(bus0.any_busy), 192'(1'b0));
    // Writes and issues presented while reset is held must be discarded.
    bus0.wen = 1'b1; bus0.waddr = 5'd9; bus0.wdata = 32'h99;
    bus0.issue_valid = 1'b1; bus0.issue_rd = 5'd9;
    @(posedge clk);
    @(negedge clk);
    bus0.wen = 1'b0; bus0.issue_valid = 1'b0; bus0.raddr = {5'd9, 5'd9};
    rst = 1'b0;
    #1;
    check("reset discards write r9", 192'(bus0.rdata[31:0]), 192'(32'h0));
    check("reset discards issue rbusy", 192'(bus0.rbusy), 192'(2'b00));
    check("reset discards issue any", 192'(bus0.any_busy), 192'(1'b0));

    // Random traffic on the second instance; its state is all zero after the reset above.
    for (int k = 0; k < 16; k++) m_rf[k] = '0;
    m_busy = '0;
    for (int c = 0; c < 2000; c++) begin
      logic [3:0]   ra [3];
      logic [191:0] exp_rd;
      logic [2:0]   exp_rb;
      logic [3:0]   wa;
      logic [3:0]   ia;
      logic [63:0]  wd;
      logic         we;
      logic         iv;
      @(negedge clk);
      we = ($urandom_range(0, 1) == 1);
      iv = ($urandom_range(0, 2) == 0);
      wa = 4'($urandom_range(0, 15));
      ia = 4'($urandom_range(0, 15));
      wd = {$urandom, $urandom};
      for (int p = 0; p < 3; p++) begin
        ra[p] = ($urandom_range(0, 3) == 0) ? wa : 4'($urandom_range(0, 15));
      end
      bus1.wen = we; bus1.waddr = wa; bus1.wdata = wd;
      bus1.issue_valid = iv; bus1.issue_rd = ia;
      bus1.raddr = {ra[2], ra[1], ra[0]};
      #1;
      exp_rd = '0;
      exp_rb = '0;
      for (int p = 0; p < 3; p++) begin
        if (ra[p] == 4'd0) begin
          exp_rd[p*64 +: 64] = 64'h0;
        end else if (we && wa == ra[p]) begin
          exp_rd[p*64 +: 64] = wd;
        end else begin
          exp_rd[p*64 +: 64] = m_rf[ra[p]];
          exp_rb[p]          = m_busy[ra[p]];
        end
      end
      check($sformatf("rnd%0d rdata", c), bus1.rdata, exp_rd);
      check($sformatf("rnd%0d rbusy", c), 192'(bus1.rbusy), 192'(exp_rb));
      check($sformatf("rnd%0d any_busy", c), 192'(bus1.any_busy), 192'(m_busy != 16'h0));
      if (we && wa != 4'd0) m_rf[wa] = wd;
      if (we) m_busy[wa] = 1'b0;
      if (iv) m_busy[ia] = 1'b1;
      m_busy[0] = 1'b0;
    end

    @(negedge clk);
    bus1.wen = 1'b0; bus1.issue_valid = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
